// File: rtl/amuxbus_arbiter.sv
// Round-robin owner of one analog mux bus with break-before-make dead time around every switch change.
// Grant follows a sampled request by BBM_CYCLES edges; requesters hold req level (no handshake), preempted ones must drop req first.
module amuxbus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int BBM_CYCLES = 4,
  parameter int MAX_HOLD   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         sw_en,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic                     busy,
  output logic                     preempt
);

  localparam int          IDW      = $clog2(N_REQ);
  localparam logic [7:0]  BBM_INIT = 8'(BBM_CYCLES - 1);
  localparam logic [15:0] HOLD_LIM = (MAX_HOLD == 0) ? 16'd0 : 16'(MAX_HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAKE, S_OWN, S_BREAK} state_t;

  state_t           state_q;
  logic [IDW-1:0]   owner_q;
  logic [IDW-1:0]   rr_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] mask_q;
  logic [N_REQ-1:0] mask_d;
  logic [7:0]       bbm_cnt_q;
  logic [15:0]      hold_cnt_q;
  logic             busy_q;
  logic             preempt_q;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] owner_oh;
  logic             win_vld;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand;
  logic             others_wait;
  logic             timeout;
  logic             own_drop;
  logic             preempt_now;

  assign elig        = req & ~mask_q;
  assign owner_oh    = N_REQ'(1) << owner_q;
  assign others_wait = |(req & ~mask_q & ~owner_oh);
  assign timeout     = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM) && others_wait;
  assign own_drop    = !req[owner_q] || !en;
  // A request drop (or disable) on the timeout edge is an ordinary release, not a preemption.
  assign preempt_now = (state_q == S_OWN) && !own_drop && timeout;

  // Search starts just after the last owner, so that owner ends up lowest priority.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = IDW'((int'(rr_q) + i) % N_REQ);
      if (elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    mask_d = mask_q & req;
    if (preempt_now) mask_d[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      rr_q       <= IDW'(N_REQ - 1);
      gnt_q      <= '0;
      mask_q     <= '0;
      bbm_cnt_q  <= '0;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      preempt_q <= preempt_now;
      case (state_q)
        S_IDLE: begin
          if (en && win_vld) begin
            owner_q   <= win_idx;
            bbm_cnt_q <= BBM_INIT;
            state_q   <= S_MAKE;
            busy_q    <= 1'b1;
          end
        end
        S_MAKE: begin
          if (own_drop) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            busy_q  <= 1'b0;
          end else if (bbm_cnt_q == 8'd0) begin
            state_q    <= S_OWN;
            gnt_q      <= owner_oh;
            hold_cnt_q <= '0;
            rr_q       <= owner_q;
          end else begin
            bbm_cnt_q <= bbm_cnt_q - 8'd1;
          end
        end
        S_OWN: begin
          if (own_drop || timeout) begin
            gnt_q     <= '0;
            bbm_cnt_q <= BBM_INIT;
            state_q   <= S_BREAK;
          end else if (hold_cnt_q != 16'hFFFF) begin
            hold_cnt_q <= hold_cnt_q + 16'd1;
          end
        end
        S_BREAK: begin
          if (bbm_cnt_q == 8'd0) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            bbm_cnt_q <= bbm_cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign sw_en    = gnt_q;
  assign owner_id = owner_q;
  assign busy     = busy_q;
  assign preempt  = preempt_q;

endmodule

// File: tb/tb_amuxbus_arbiter.sv
// Directed bench for amuxbus_arbiter: one unlimited-hold instance and one MAX_HOLD=8 instance.
module tb_amuxbus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] req_mh;

  logic [3:0] gnt, sw_en, gnt_mh, sw_en_mh;
  logic [1:0] owner_id, owner_id_mh;
  logic       busy, preempt, busy_mh, preempt_mh;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  amuxbus_arbiter #(.N_REQ(4), .BBM_CYCLES(4), .MAX_HOLD(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt), .sw_en(sw_en), .owner_id(owner_id), .busy(busy), .preempt(preempt)
  );

  amuxbus_arbiter #(.N_REQ(4), .BBM_CYCLES(4), .MAX_HOLD(8)) dut_mh (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req_mh),
    .gnt(gnt_mh), .sw_en(sw_en_mh), .owner_id(owner_id_mh), .busy(busy_mh), .preempt(preempt_mh)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
  endtask

  // Advance until the main instance grants something, then compare with the expected one-hot.
  task automatic wait_gnt(input string tag, input logic [3:0] exp, input int limit);
    int n;
    n = 0;
    while (gnt == 4'b0000 && n < limit) begin
      tick();
      n++;
    end
    check(tag, 16'(gnt), 16'(exp));
  endtask

  // Switch-safety invariants on both instances, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("onehot_sw", 16'($onehot0(sw_en)), 16'd1);
      check("gnt_eq_sw", 16'(gnt), 16'(sw_en));
      check("onehot_sw_mh", 16'($onehot0(sw_en_mh)), 16'd1);
      check("gnt_eq_sw_mh", 16'(gnt_mh), 16'(sw_en_mh));
    end
  end

  initial begin
    rst_n  = 1'b1;
    en     = 1'b0;
    req    = 4'b0000;
    req_mh = 4'b0000;
    #2;
    do_reset();

    // Reset values
    check("rst_gnt", 16'(gnt), 16'h0);
    check("rst_owner", 16'(owner_id), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_preempt", 16'(preempt), 16'h0);

    // 1: single request, grant 4 edges after the sampling edge
    en  = 1'b1;
    req = 4'b0001;
    tick();
    check("t1_make_gnt", 16'(gnt), 16'h0);
    check("t1_make_busy", 16'(busy), 16'h1);
    check("t1_make_owner", 16'(owner_id), 16'h0);
    ticks(3);
    check("t1_pre_gnt", 16'(gnt), 16'h0);
    tick();
    check("t1_gnt", 16'(gnt), 16'h1);
    check("t1_sw_en", 16'(sw_en), 16'h1);
    check("t1_owner", 16'(owner_id), 16'h0);
    check("t1_busy", 16'(busy), 16'h1);

    // 2: second requester waits; owner drop -> 9 edges of dead time/re-arbitration
    req = 4'b0011;
    ticks(5);
    check("t2_hold", 16'(gnt), 16'h1);
    check("t2_no_preempt", 16'(preempt), 16'h0);
    req = 4'b0010;
    tick();
    check("t2_drop_off", 16'(sw_en), 16'h0);
    ticks(3);
    check("t2_break_off", 16'(sw_en), 16'h0);
    check("t2_break_busy", 16'(busy), 16'h1);
    tick();
    check("t2_idle_busy", 16'(busy), 16'h0);
    tick();
    check("t2_make_owner", 16'(owner_id), 16'h1);
    ticks(3);
    check("t2_make_off", 16'(sw_en), 16'h0);
    tick();
    check("t2_gnt1", 16'(gnt), 16'h2);
    check("t2_owner1", 16'(owner_id), 16'h1);
    req = 4'b0000;
    ticks(6);
    check("t2_end_busy", 16'(busy), 16'h0);

    // 3: all four request; each owner drops 10 cycles after grant
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] exp;
      exp = 4'b0001 << (i % 4);
      wait_gnt($sformatf("t3_order%0d", i), exp, 20);
      ticks(9);
      req = 4'b1111 & ~exp;
      tick();
      check($sformatf("t3_release%0d", i), 16'(gnt), 16'h0);
      req = 4'b1111;
    end
    req = 4'b0000;
    ticks(10);
    check("t3_end_busy", 16'(busy), 16'h0);

    // 4: MAX_HOLD=8 preemption and mask
    do_reset();
    req_mh = 4'b0011;
    ticks(5);
    check("t4_gnt0", 16'(gnt_mh), 16'h1);
    ticks(7);
    check("t4_hold7", 16'(gnt_mh), 16'h1);
    check("t4_no_pulse_yet", 16'(preempt_mh), 16'h0);
    tick();
    check("t4_removed", 16'(gnt_mh), 16'h0);
    check("t4_preempt", 16'(preempt_mh), 16'h1);
    tick();
    check("t4_preempt_1cyc", 16'(preempt_mh), 16'h0);
    ticks(7);
    check("t4_dead", 16'(sw_en_mh), 16'h0);
    tick();
    check("t4_gnt1", 16'(gnt_mh), 16'h2);
    ticks(20);
    check("t4_gnt1_kept", 16'(gnt_mh), 16'h2);
    check("t4_no_preempt1", 16'(preempt_mh), 16'h0);
    req_mh = 4'b0001;
    ticks(15);
    check("t4_masked", 16'(gnt_mh), 16'h0);
    check("t4_masked_busy", 16'(busy_mh), 16'h0);
    req_mh = 4'b0000;
    tick();
    req_mh = 4'b0001;
    ticks(5);
    check("t4_regrant0", 16'(gnt_mh), 16'h1);
    req_mh = 4'b0000;
    ticks(6);

    // 5: en dropped while owning
    req = 4'b0001;
    ticks(5);
    check("t5_gnt", 16'(gnt), 16'h1);
    en = 1'b0;
    tick();
    check("t5_off", 16'(sw_en), 16'h0);
    check("t5_break_busy", 16'(busy), 16'h1);
    ticks(3);
    check("t5_break_busy3", 16'(busy), 16'h1);
    tick();
    check("t5_idle", 16'(busy), 16'h0);
    ticks(6);
    check("t5_no_gnt", 16'(gnt), 16'h0);
    check("t5_no_busy", 16'(busy), 16'h0);
    en = 1'b1;
    ticks(5);
    check("t5_regrant", 16'(gnt), 16'h1);

    // 6: asynchronous reset while owning
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_gnt", 16'(gnt), 16'h0);
    check("t6_sw_en", 16'(sw_en), 16'h0);
    check("t6_busy", 16'(busy), 16'h0);
    check("t6_owner", 16'(owner_id), 16'h0);
    check("t6_preempt", 16'(preempt), 16'h0);
    req = 4'b0000;
    tick();
    rst_n = 1'b1;
    ticks(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
